led_pwm_fader: RTL and testbench

LED_PWM_FADER -- requirements
Module: led_pwm_fader

---
 rtl/led_pwm_fader_if.sv | 9 +
 rtl/led_pwm_fader.sv | 70 +++++++
 tb/tb_led_pwm_fader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: LED request, fade mode and PWM/busy status bundle
interface led_pwm_fader_if;
   logic [3:0] led_in;
   logic       fade_en;
   logic [3:0] led_out;
   logic [3:0] busy;
   modport master (output led_in, fade_en, input led_out, busy);
   modport slave  (input led_in, fade_en, output led_out, busy);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: four-channel LED PWM driver with per-channel linear fade
module led_pwm_fader #(
   parameter int unsigned STEP_DIV  = 195_312,
   parameter int unsigned FADE_STEP = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   led_pwm_fader_if.slave bus
);
   typedef enum logic [1:0] {OFF, RISING, ON, FALLING} state_t;
   localparam logic [23:0] DIV_MAX = 24'(STEP_DIV - 1);
   localparam logic [8:0]  STEP9   = 9'(FADE_STEP);
   localparam logic [7:0]  STEP8   = 8'(FADE_STEP);
   logic [3:0]      led_r;
   logic [23:0]     pre_q;
   logic [7:0]      pwm_q;
   logic            step_tick;
   logic [3:0][7:0] duty_q, duty_n;
   state_t          state_q [4];
   state_t          state_n [4];
   logic [3:0]      led_q, busy_q;
   logic [8:0]      up;
   logic [7:0]      dn, sd;
   assign step_tick   = pre_q == DIV_MAX;
   assign bus.led_out = led_q;
   assign bus.busy    = busy_q;
   // Ramping states follow led_r as direction, so a reversal steps the new way at once
   always_comb begin
      duty_n = duty_q;
      up     = '0;
      dn     = '0;
      sd     = '0;
      for (int i = 0; i < 4; i++) begin
         state_n[i] = state_q[i];
         up = {1'b0, duty_q[i]} + STEP9;
         dn = duty_q[i] > STEP8 ? duty_q[i] - STEP8 : 8'd0;
         sd = !step_tick ? duty_q[i] : led_r[i] ? (up[8] ? 8'hff : up[7:0]) : dn;
         if (!bus.fade_en) begin
            duty_n[i]  = {8{led_r[i]}};
            state_n[i] = led_r[i] ? ON : OFF;
         end else if (state_q[i] == OFF || state_q[i] == ON) begin
            state_n[i] = (led_r[i] == (state_q[i] == ON)) ? state_q[i] : led_r[i] ? RISING : FALLING;
         end else begin
            duty_n[i]  = sd;
            state_n[i] = led_r[i] ? (sd == 8'hff ? ON : RISING) : (sd == 8'h00 ? OFF : FALLING);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_r  <= '0;
         pre_q  <= '0;
         pwm_q  <= '0;
         duty_q <= '0;
         led_q  <= '0;
         busy_q <= '0;
         for (int i = 0; i < 4; i++) state_q[i] <= OFF;
      end else begin
         led_r  <= bus.led_in;
         pre_q  <= step_tick ? 24'd0 : pre_q + 24'd1;
         pwm_q  <= pwm_q + 8'd1;
         duty_q <= duty_n;
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_n[i];
            led_q[i]   <= duty_q[i] > pwm_q;
            busy_q[i]  <= state_n[i] == RISING || state_n[i] == FALLING;
         end
      end
   end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: scoreboard bench for the LED fader, fast-step and slow-step instances
module tb_led_pwm_fader;
   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;
   led_pwm_fader_if bus ();
   led_pwm_fader_if bus2 ();
   led_pwm_fader #(.STEP_DIV(2), .FADE_STEP(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   led_pwm_fader #(.STEP_DIV(2048), .FADE_STEP(128)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   typedef struct packed {logic [7:0] duty; logic busy;} exp_t;
   exp_t q[$];
   int total = 0;
   int passed = 0;
   logic mon_en = 0;
   int mon_ch = 0;
   logic [3:0][7:0] prev;
   logic [7:0] cur;
   exp_t e;
   always @(posedge clk) begin
      #1;
      cur = dut.duty_q[mon_ch];
      if (mon_en && cur !== prev[mon_ch]) begin
         total++;
         if (q.size() == 0) $display("FAIL unexpected_change ch%0d: got duty %0d, required no change from %0d", mon_ch, cur, prev[mon_ch]);
         else begin
            e = q.pop_front();
            if (cur !== e.duty || bus.busy[mon_ch] !== e.busy)
               $display("FAIL step ch%0d: got duty %0d busy %0b, required duty %0d busy %0b", mon_ch, cur, bus.busy[mon_ch], e.duty, e.busy);
            else passed++;
         end
      end
      prev = dut.duty_q;
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      #2;
      total++; if (bus.led_out !== 4'b0) $display("FAIL reset_led_out: got %b, required 0000", bus.led_out); else passed++;
      total++; if (bus.busy !== 4'b0) $display("FAIL reset_busy: got %b, required 0000", bus.busy); else passed++;
      total++; if (dut.duty_q !== 32'd0) $display("FAIL reset_duty: got %h, required 0", dut.duty_q); else passed++;
      total++; if (bus2.led_out !== 4'b0 || bus2.busy !== 4'b0) $display("FAIL reset_dut2: got %b/%b, required 0000/0000", bus2.led_out, bus2.busy); else passed++;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      cyc();
   endtask
   task automatic test_rise();
      q.push_back({8'd64, 1'b1});
      q.push_back({8'd128, 1'b1});
      q.push_back({8'd192, 1'b1});
      q.push_back({8'd255, 1'b0});
      mon_ch = 0;
      mon_en = 1;
      bus.led_in = 4'b0001;
      for (int n = 0; n < 40 && q.size() != 0; n++) cyc();
      total++; if (q.size() != 0) $display("FAIL rise_timeout: got %0d pending, required 0", q.size()); else passed++;
      cyc();
      total++; if ({dut.duty_q[3], dut.duty_q[2], dut.duty_q[1]} !== 24'd0) $display("FAIL rise_others: got %h, required 0", dut.duty_q); else passed++;
      total++; if (bus.busy !== 4'b0) $display("FAIL rise_busy_end: got %b, required 0000", bus.busy); else passed++;
   endtask
   task automatic test_fall();
      logic lit = 0;
      logic bsy = 0;
      q.push_back({8'd191, 1'b1});
      q.push_back({8'd127, 1'b1});
      q.push_back({8'd63, 1'b1});
      q.push_back({8'd0, 1'b0});
      bus.led_in = 4'b0000;
      for (int n = 0; n < 40 && q.size() != 0; n++) cyc();
      total++; if (q.size() != 0) $display("FAIL fall_timeout: got %0d pending, required 0", q.size()); else passed++;
      cyc();
      cyc();
      for (int n = 0; n < 300; n++) begin
         lit |= bus.led_out[0];
         bsy |= bus.busy[0];
         cyc();
      end
      total++; if (lit !== 1'b0) $display("FAIL fall_led_dark: got %b, required 0", lit); else passed++;
      total++; if (bsy !== 1'b0) $display("FAIL fall_busy: got %b, required 0", bsy); else passed++;
      total++; if (dut.duty_q[0] !== 8'd0) $display("FAIL fall_duty: got %0d, required 0", dut.duty_q[0]); else passed++;
   endtask
   task automatic test_reversal();
      logic found = 0;
      mon_ch = 1;
      q.push_back({8'd64, 1'b1});
      q.push_back({8'd128, 1'b1});
      bus.led_in = 4'b0010;
      for (int n = 0; n < 40 && !found; n++) begin
         cyc();
         found = dut.duty_q[1] == 8'd128;
      end
      total++; if (!found) $display("FAIL rev_reach128: got %0d, required 128", dut.duty_q[1]); else passed++;
      bus.led_in = 4'b0000;
      q.push_back({8'd64, 1'b1});
      q.push_back({8'd0, 1'b0});
      cyc();
      cyc();
      total++; if (dut.duty_q[1] !== 8'd64) $display("FAIL rev_same_tick: got %0d, required 64", dut.duty_q[1]); else passed++;
      for (int n = 0; n < 40 && q.size() != 0; n++) cyc();
      total++; if (q.size() != 0) $display("FAIL rev_timeout: got %0d pending, required 0", q.size()); else passed++;
      repeat (6) cyc();
   endtask
   task automatic test_direct();
      int c1 = 0;
      int c3 = 0;
      logic bsy = 0;
      q.push_back({8'd255, 1'b0});
      bus.fade_en = 0;
      bus.led_in = 4'b1010;
      cyc();
      total++; if (dut.duty_q[1] !== 8'd0) $display("FAIL direct_latency: got %0d, required 0", dut.duty_q[1]); else passed++;
      cyc();
      total++; if (dut.duty_q[3] !== 8'd255 || dut.duty_q[1] !== 8'd255) $display("FAIL direct_duty: got %0d/%0d, required 255/255", dut.duty_q[1], dut.duty_q[3]); else passed++;
      total++; if (dut.duty_q[0] !== 8'd0 || dut.duty_q[2] !== 8'd0) $display("FAIL direct_others: got %0d/%0d, required 0/0", dut.duty_q[0], dut.duty_q[2]); else passed++;
      cyc();
      for (int n = 0; n < 256; n++) begin
         c1 += int'(bus.led_out[1]);
         c3 += int'(bus.led_out[3]);
         bsy |= |bus.busy;
         cyc();
      end
      total++; if (c1 != 255) $display("FAIL direct_pwm1: got %0d lit cycles, required 255", c1); else passed++;
      total++; if (c3 != 255) $display("FAIL direct_pwm3: got %0d lit cycles, required 255", c3); else passed++;
      total++; if (bsy !== 1'b0) $display("FAIL direct_busy: got %b, required 0", bsy); else passed++;
      total++; if (q.size() != 0) $display("FAIL direct_sb: got %0d pending, required 0", q.size()); else passed++;
      mon_en = 0;
   endtask
   task automatic test_duty128();
      logic found = 0;
      int h = 0;
      int l = 0;
      bus2.led_in = 4'b0100;
      for (int n = 0; n < 5000 && !found; n++) begin
         cyc();
         found = dut2.duty_q[2] == 8'd128;
      end
      total++; if (!found) $display("FAIL d128_reach: got %0d, required 128", dut2.duty_q[2]); else passed++;
      for (int n = 0; n < 300 && bus2.led_out[2] !== 1'b0; n++) cyc();
      for (int n = 0; n < 300 && bus2.led_out[2] !== 1'b1; n++) cyc();
      while (bus2.led_out[2] === 1'b1 && h < 300) begin h++; cyc(); end
      while (bus2.led_out[2] === 1'b0 && l < 300) begin l++; cyc(); end
      total++; if (h != 128) $display("FAIL d128_high: got %0d cycles, required 128", h); else passed++;
      total++; if (l != 128) $display("FAIL d128_low: got %0d cycles, required 128", l); else passed++;
   endtask
   task automatic test_reset_mid();
      int n = 0;
      total++; if (bus2.busy[2] !== 1'b1) $display("FAIL mid_busy_before: got %b, required 1", bus2.busy[2]); else passed++;
      for (int k = 0; k < 300 && bus2.led_out[2] !== 1'b1; k++) cyc();
      #2 rst_n = 0;
      #1;
      total++; if (bus2.led_out !== 4'b0) $display("FAIL mid_led_async: got %b, required 0000", bus2.led_out); else passed++;
      total++; if (bus2.busy !== 4'b0) $display("FAIL mid_busy_async: got %b, required 0000", bus2.busy); else passed++;
      total++; if (dut2.duty_q[2] !== 8'd0) $display("FAIL mid_duty_async: got %0d, required 0", dut2.duty_q[2]); else passed++;
      repeat (2) cyc();
      rst_n = 1;
      while (dut2.duty_q[2] === 8'd0 && n < 3000) begin cyc(); n++; end
      total++; if (n != 2048) $display("FAIL mid_first_tick: got %0d cycles, required 2048", n); else passed++;
      total++; if (dut2.duty_q[2] !== 8'd128) $display("FAIL mid_restart: got %0d, required 128", dut2.duty_q[2]); else passed++;
      total++; if (bus2.busy[2] !== 1'b1) $display("FAIL mid_busy_after: got %b, required 1", bus2.busy[2]); else passed++;
   endtask
   initial begin
      bus.led_in = 0;
      bus.fade_en = 1;
      bus2.led_in = 0;
      bus2.fade_en = 1;
      test_reset();
      test_rise();
      test_fall();
      test_reversal();
      test_direct();
      test_duty128();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
